// File: rtl/aibnd_clkdiv_gate.sv
`default_nettype none
// ============================================================================
// Module   : aibnd_clkdiv_gate
// Purpose  : Gated, programmable clock divider for the IO datapath. Produces
//            a 50%-duty divided clock (period 2N) and a one-cycle strobe at
//            the end of every N-cycle period. Start and stop are glitch-free,
//            and a settle window precedes the ready indication.
// Revision : 1.0 - initial release
// ============================================================================
module aibnd_clkdiv_gate #(
    parameter int DIV_W      = 4,
    parameter int SETTLE_CNT = 8
) (
    input  logic             clkin,
    input  logic             reset,
    inout  wire              vccl,
    inout  wire              vssl,
    input  logic             div_en,
    input  logic [DIV_W-1:0] div_ratio,
    output logic             clkdiv,
    output logic             clkdiv_pulse,
    output logic             ready
);

    localparam logic [1:0]       c_IDLE        = 2'd0;
    localparam logic [1:0]       c_SETTLE      = 2'd1;
    localparam logic [1:0]       c_RUN         = 2'd2;
    localparam logic [1:0]       c_DRAIN       = 2'd3;
    localparam logic [DIV_W-1:0] c_ONE         = DIV_W'(1);
    localparam logic [7:0]       c_SETTLE_LAST = 8'(SETTLE_CNT - 1);

    logic [1:0]       r_state;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_ratio_q;
    logic [7:0]       r_settle_cnt;
    logic             r_clkdiv;

    logic [DIV_W-1:0] w_ratio_eff;
    logic             w_last;
    logic             w_counting;
    logic             w_unused_supply;

    // Supply pins carry no logic; fold them into a deliberately unused net.
    assign w_unused_supply = vccl ^ vssl;

    // A programmed ratio of zero behaves as divide-by-one.
    assign w_ratio_eff = (div_ratio == '0) ? c_ONE : div_ratio;
    assign w_last      = (r_cnt == (r_ratio_q - c_ONE));
    assign w_counting  = (r_state == c_RUN) || (r_state == c_DRAIN);

    assign clkdiv       = r_clkdiv;
    assign clkdiv_pulse = w_counting && w_last;
    assign ready        = (r_state == c_RUN);

    // Sequencer: settle window, divide counter, and glitch-free stop.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_cnt        <= '0;
            r_ratio_q    <= c_ONE;
            r_settle_cnt <= 8'd0;
            r_clkdiv     <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_cnt    <= '0;
                    r_clkdiv <= 1'b0;
                    if (div_en) begin
                        r_state      <= c_SETTLE;
                        r_settle_cnt <= 8'd0;
                        r_ratio_q    <= w_ratio_eff;
                    end
                end
                c_SETTLE: begin
                    r_settle_cnt <= r_settle_cnt + 8'd1;
                    // Withdrawal wins over settle completion; clkdiv is low here.
                    if (!div_en) begin
                        r_state <= c_IDLE;
                    end else if (r_settle_cnt == c_SETTLE_LAST) begin
                        r_state <= c_RUN;
                        r_cnt   <= '0;
                    end
                end
                c_RUN: begin
                    if (w_last) begin
                        r_cnt     <= '0;
                        r_ratio_q <= w_ratio_eff;
                        r_clkdiv  <= ~r_clkdiv;
                    end else begin
                        r_cnt <= r_cnt + c_ONE;
                    end
                    if (!div_en) begin
                        r_state <= c_DRAIN;
                    end
                end
                default: begin
                    // DRAIN: a low clkdiv may stop now; a high one must finish
                    // its half-period so the final high phase is full length.
                    if (!r_clkdiv) begin
                        r_state <= c_IDLE;
                        r_cnt   <= '0;
                    end else if (w_last) begin
                        r_state   <= c_IDLE;
                        r_cnt     <= '0;
                        r_ratio_q <= w_ratio_eff;
                        r_clkdiv  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + c_ONE;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aibnd_clkdiv_gate.sv
`default_nettype none
// ============================================================================
// Module   : tb_aibnd_clkdiv_gate
// Purpose  : Self-checking bench for aibnd_clkdiv_gate. A period-level model
//            (remaining cycles in the current half-period, output level,
//            settle progress) predicts every output each cycle; directed
//            steps cover the listed scenarios, followed by random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aibnd_clkdiv_gate;

    localparam int DIV_W      = 4;
    localparam int SETTLE_CNT = 8;

    localparam int M_IDLE   = 0;
    localparam int M_SETTLE = 1;
    localparam int M_RUN    = 2;
    localparam int M_DRAIN  = 3;

    logic             clkin     = 1'b0;
    logic             reset     = 1'b1;
    logic             div_en    = 1'b0;
    logic [DIV_W-1:0] div_ratio = '0;
    wire              vccl      = 1'b1;
    wire              vssl      = 1'b0;
    logic             clkdiv;
    logic             clkdiv_pulse;
    logic             ready;

    aibnd_clkdiv_gate #(
        .DIV_W      (DIV_W),
        .SETTLE_CNT (SETTLE_CNT)
    ) u_dut (
        .clkin        (clkin),
        .reset        (reset),
        .vccl         (vccl),
        .vssl         (vssl),
        .div_en       (div_en),
        .div_ratio    (div_ratio),
        .clkdiv       (clkdiv),
        .clkdiv_pulse (clkdiv_pulse),
        .ready        (ready)
    );

    always #5 clkin = ~clkin;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    int m_mode   = M_IDLE;
    int m_waited = 0;      // settle cycles completed
    int m_n      = 1;      // current period length
    int m_left   = 1;      // cycles remaining in current period, 1 = strobe cycle
    bit m_clk    = 1'b0;

    // Observed history for the "clkdiv only moves after a strobe" rule
    logic prev_clk   = 1'b0;
    logic prev_pulse = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_mode   = M_IDLE;
        m_waited = 0;
        m_n      = 1;
        m_left   = 1;
        m_clk    = 1'b0;
        prev_clk   = 1'b0;
        prev_pulse = 1'b0;
    endtask

    task automatic model_step();
        int eff;
        eff = (div_ratio == '0) ? 1 : int'(div_ratio);
        case (m_mode)
            M_IDLE: begin
                m_clk = 1'b0;
                if (div_en) begin
                    m_mode   = M_SETTLE;
                    m_waited = 0;
                    m_n      = eff;
                end
            end
            M_SETTLE: begin
                if (!div_en) begin
                    m_mode = M_IDLE;
                end else begin
                    m_waited++;
                    if (m_waited == SETTLE_CNT) begin
                        m_mode = M_RUN;
                        m_left = m_n;
                    end
                end
            end
            M_RUN: begin
                if (m_left == 1) begin
                    m_clk  = !m_clk;
                    m_n    = eff;
                    m_left = eff;
                end else begin
                    m_left--;
                end
                if (!div_en) m_mode = M_DRAIN;
            end
            default: begin
                if (!m_clk) begin
                    m_mode = M_IDLE;
                end else if (m_left == 1) begin
                    m_clk  = 1'b0;
                    m_mode = M_IDLE;
                end else begin
                    m_left--;
                end
            end
        endcase
    endtask

    task automatic check_model();
        logic exp_pulse;
        exp_pulse = ((m_mode == M_RUN) || (m_mode == M_DRAIN)) && (m_left == 1);
        chk("clkdiv", clkdiv, m_clk);
        chk("pulse", clkdiv_pulse, exp_pulse);
        chk("ready", ready, m_mode == M_RUN);
        if (!prev_pulse) chk("clk_hold", clkdiv, prev_clk);
        prev_clk   = clkdiv;
        prev_pulse = clkdiv_pulse;
    endtask

    task automatic tick();
        @(posedge clkin);
        model_step();
        #1;
        check_model();
    endtask

    task automatic tick_n(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    initial begin
        bit found;

        // Reset state
        #2;
        chk("rst_clkdiv", clkdiv, 1'b0);
        chk("rst_pulse", clkdiv_pulse, 1'b0);
        chk("rst_ready", ready, 1'b0);
        @(posedge clkin);
        #1;
        reset = 1'b0;
        model_reset();
        tick_n(2);

        // Start at N=3: ready after SETTLE_CNT+1 edges
        div_ratio = 4'd3;
        div_en    = 1'b1;
        tick_n(SETTLE_CNT);
        chk("lat_not_yet", ready, 1'b0);
        tick();
        chk("lat_ready", ready, 1'b1);
        tick_n(2);
        chk("n3_first_pulse", clkdiv_pulse, 1'b1);
        tick();
        chk("n3_first_rise", clkdiv, 1'b1);
        tick_n(18);

        // Ratio change mid-period only affects the next period
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (m_mode == M_RUN && m_n == 3 && m_left == 2) found = 1'b1;
            else tick();
        end
        chk("wait_cnt1", found, 1'b1);
        div_ratio = 4'd5;
        tick();
        chk("old_period_end", clkdiv_pulse, 1'b1);
        tick_n(4);
        chk("new_mid", clkdiv_pulse, 1'b0);
        tick();
        chk("new_period_end", clkdiv_pulse, 1'b1);
        tick_n(20);

        // Stop while clkdiv high at cnt=0 with N=4: full high phase, no runt
        div_ratio = 4'd4;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (m_mode == M_RUN && m_n == 4 && m_left == 4 && m_clk) found = 1'b1;
            else tick();
        end
        chk("wait_hi_cnt0", found, 1'b1);
        chk("pre_stop_clk", clkdiv, 1'b1);
        div_en = 1'b0;
        tick();
        chk("drain_ready", ready, 1'b0);
        chk("drain_hi1", clkdiv, 1'b1);
        tick();
        chk("drain_hi2", clkdiv, 1'b1);
        tick();
        chk("drain_hi3", clkdiv, 1'b1);
        chk("drain_pulse", clkdiv_pulse, 1'b1);
        tick();
        chk("drain_low", clkdiv, 1'b0);
        tick_n(3);
        chk("idle_low", clkdiv, 1'b0);

        // Ratio 0 behaves as divide-by-one
        div_ratio = 4'd0;
        div_en    = 1'b1;
        tick_n(SETTLE_CNT + 1);
        chk("n1_ready", ready, 1'b1);
        for (int i = 0; i < 6; i++) begin
            chk("n1_pulse", clkdiv_pulse, 1'b1);
            tick();
        end
        div_en = 1'b0;
        tick_n(4);
        chk("n1_stop_low", clkdiv, 1'b0);

        // Withdraw during SETTLE, then a fresh full window
        div_ratio = 4'd2;
        div_en    = 1'b1;
        tick_n(4);
        div_en = 1'b0;
        tick();
        chk("abort_ready", ready, 1'b0);
        div_en = 1'b1;
        tick_n(SETTLE_CNT);
        chk("resettle_not_yet", ready, 1'b0);
        tick();
        chk("resettle_ready", ready, 1'b1);
        tick_n(7);

        // Asynchronous reset mid-stream
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (m_clk) found = 1'b1;
            else tick();
        end
        chk("wait_clk_hi", found, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_clkdiv", clkdiv, 1'b0);
        chk("async_pulse", clkdiv_pulse, 1'b0);
        chk("async_ready", ready, 1'b0);
        model_reset();
        div_en = 1'b0;
        @(negedge clkin);
        reset = 1'b0;
        tick_n(2);

        // Random traffic
        div_en = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 24) == 0) div_en = ~div_en;
            if ($urandom_range(0, 7) == 0) div_ratio = DIV_W'($urandom_range(0, 15));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
